// File: rtl/rob_recovery_ctrl_pkg.sv
// Shared types for the ROB misprediction recovery sequencer.
// Imported by the recovery controller, its interface and the fetch side.
package rob_recovery_ctrl_pkg;

  localparam int ROB_ID_WIDTH = 6;
  localparam int PC_WIDTH     = 32;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    FLUSH,
    REDIRECT,
    RESUME
  } recov_state_t;

  typedef enum logic {
    CAUSE_BR,
    CAUSE_LD
  } recov_cause_t;

  typedef struct packed {
    logic                valid;
    logic [PC_WIDTH-1:0] pc;
  } redirect_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rob_recovery_ctrl_if.sv
// ROB head / drain / fetch redirect bundle for the recovery sequencer.
// slave is the controller side, master drives the head and handshakes.
interface rob_recovery_ctrl_if
  import rob_recovery_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);

  logic                    head_valid;
  logic [ROB_ID_WIDTH-1:0] head_rob_id;
  logic                    head_reg_ready;
  logic                    head_br_mispred;
  logic                    head_ld_mispred;
  logic [ADDR_WIDTH-1:0]   head_pc;
  logic [ADDR_WIDTH-1:0]   head_npc;
  logic                    fu_idle;
  logic                    redirect_ready;
  logic                    dispatch_stall;
  logic                    flush;
  logic                    br_commit;
  logic [ROB_ID_WIDTH-1:0] commit_rob_id;
  logic                    redirect_valid;
  logic [ADDR_WIDTH-1:0]   redirect_pc;
  logic                    busy;
  logic [CNT_WIDTH-1:0]    mispred_cnt;

  modport slave (
    input  head_valid, head_rob_id, head_reg_ready,
    input  head_br_mispred, head_ld_mispred,
    input  head_pc, head_npc, fu_idle, redirect_ready,
    output dispatch_stall, flush, br_commit,
    output commit_rob_id, redirect_valid, redirect_pc,
    output busy, mispred_cnt
  );

  modport master (
    output head_valid, head_rob_id, head_reg_ready,
    output head_br_mispred, head_ld_mispred,
    output head_pc, head_npc, fu_idle, redirect_ready,
    input  dispatch_stall, flush, br_commit,
    input  commit_rob_id, redirect_valid, redirect_pc,
    input  busy, mispred_cnt
  );

endinterface

// File: rtl/rob_recovery_ctrl_sat_counter.sv
// Saturating up-counter for performance events.
// Holds at all-ones once reached; clears on async reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  // count events, stopping at the maximum value
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/rob_recovery_ctrl.sv
// Misprediction recovery sequencer beside the ROB head.
// Stall, drain, flush, redirect fetch, then release dispatch.
module rob_recovery_ctrl
  import rob_recovery_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DRAIN_TIMEOUT = 15,
  parameter int RESUME_CYCLES = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                clk,
  input  logic                rst_aL,
  rob_recovery_ctrl_if.slave  bus
);

  localparam int TMAX = max_int(DRAIN_TIMEOUT, RESUME_CYCLES);
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [TW-1:0] RES_LOAD   = TW'(RESUME_CYCLES);

  recov_state_t            r_state;
  recov_state_t            w_next;
  recov_cause_t            r_cause;
  logic [ADDR_WIDTH-1:0]   r_target;
  logic [ROB_ID_WIDTH-1:0] r_rob_id;
  logic [TW-1:0]           r_drain_cnt;
  logic [TW-1:0]           r_res_cnt;
  logic                    w_trigger;
  logic                    w_start;
  logic                    w_drain_done;
  logic                    w_accept;

  assign w_trigger = bus.head_valid & bus.head_reg_ready &
                     (bus.head_br_mispred | bus.head_ld_mispred);
  assign w_start   = (r_state == IDLE) & w_trigger;
  // DRAIN_LAST: the cycle counter saturates the stay at DRAIN_TIMEOUT cycles
  assign w_drain_done = bus.fu_idle | (r_drain_cnt == DRAIN_LAST);
  assign w_accept  = (r_state == REDIRECT) & bus.redirect_ready;

  // state register
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state and per-state control outputs
  always_comb begin
    w_next             = r_state;
    bus.dispatch_stall = 1'b0;
    bus.flush          = 1'b0;
    bus.br_commit      = 1'b0;
    bus.redirect_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_trigger) w_next = DRAIN;
      end
      DRAIN: begin
        bus.dispatch_stall = 1'b1;
        if (w_drain_done) w_next = FLUSH;
      end
      FLUSH: begin
        bus.dispatch_stall = 1'b1;
        bus.flush          = 1'b1;
        bus.br_commit      = (r_cause == CAUSE_BR);
        w_next             = REDIRECT;
      end
      REDIRECT: begin
        bus.dispatch_stall = 1'b1;
        bus.redirect_valid = 1'b1;
        if (bus.redirect_ready) w_next = RESUME;
      end
      RESUME: begin
        bus.dispatch_stall = 1'b1;
        if (r_res_cnt == TW'(1)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // capture cause, target and id on the trigger edge
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_cause  <= CAUSE_BR;
      r_target <= '0;
      r_rob_id <= '0;
    end else if (w_start) begin
      r_cause  <= bus.head_ld_mispred ? CAUSE_LD : CAUSE_BR;
      r_target <= bus.head_ld_mispred ? bus.head_pc : bus.head_npc;
      r_rob_id <= bus.head_rob_id;
    end
  end

  // drain timer counts cycles spent in DRAIN
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_drain_cnt <= '0;
    end else if (r_state == DRAIN && !w_drain_done) begin
      r_drain_cnt <= r_drain_cnt + TW'(1);
    end else begin
      r_drain_cnt <= '0;
    end
  end

  // resume timer loads on redirect accept, counts down in RESUME
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_res_cnt <= '0;
    end else if (w_accept) begin
      r_res_cnt <= RES_LOAD;
    end else if (r_state == RESUME && r_res_cnt != '0) begin
      r_res_cnt <= r_res_cnt - TW'(1);
    end
  end

  assign bus.busy          = (r_state != IDLE);
  assign bus.commit_rob_id = r_rob_id;
  assign bus.redirect_pc   = r_target;

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_mispred_cnt (
    .clk    (clk),
    .rst_aL (rst_aL),
    .i_inc  (w_start),
    .o_cnt  (bus.mispred_cnt)
  );

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Self-checking bench for rob_recovery_ctrl.
// Timeline model of each recovery derived from drain/backpressure lengths.
module tb_rob_recovery_ctrl;
  import rob_recovery_ctrl_pkg::*;

  localparam int AW  = 32;
  localparam int DT  = 15;
  localparam int RES = 2;
  localparam int CW  = 5;
  localparam logic [CW-1:0] CMAX = '1;

  logic clk;
  logic rst_aL;
  int   checks;
  int   errors;
  int   exp_cnt;

  rob_recovery_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  rob_recovery_ctrl #(
    .ADDR_WIDTH    (AW),
    .DRAIN_TIMEOUT (DT),
    .RESUME_CYCLES (RES),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet_inputs();
    bus.head_valid      = 1'b0;
    bus.head_rob_id     = '0;
    bus.head_reg_ready  = 1'b0;
    bus.head_br_mispred = 1'b0;
    bus.head_ld_mispred = 1'b0;
    bus.head_pc         = '0;
    bus.head_npc        = '0;
    bus.fu_idle         = 1'b1;
    bus.redirect_ready  = 1'b0;
  endtask

  task automatic garbage_head();
    bus.head_valid      = 1'($urandom);
    bus.head_rob_id     = 6'($urandom);
    bus.head_reg_ready  = 1'($urandom);
    bus.head_br_mispred = 1'($urandom);
    bus.head_ld_mispred = 1'($urandom);
    bus.head_pc         = $urandom;
    bus.head_npc        = $urandom;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_stall"}, 64'(bus.dispatch_stall), 64'd0);
    check({tag, "_flush"}, 64'(bus.flush), 64'd0);
    check({tag, "_brc"},   64'(bus.br_commit), 64'd0);
    check({tag, "_cid"},   64'(bus.commit_rob_id), 64'd0);
    check({tag, "_rv"},    64'(bus.redirect_valid), 64'd0);
    check({tag, "_rpc"},   64'(bus.redirect_pc), 64'd0);
    check({tag, "_busy"},  64'(bus.busy), 64'd0);
    check({tag, "_cnt"},   64'(bus.mispred_cnt), 64'd0);
  endtask

  task automatic idle_probe(input bit v, input bit rr,
                            input bit br, input bit ld);
    @(negedge clk);
    bus.head_valid      = v;
    bus.head_reg_ready  = rr;
    bus.head_br_mispred = br;
    bus.head_ld_mispred = ld;
    bus.head_pc         = $urandom;
    bus.head_npc        = $urandom;
    @(negedge clk);
    check("probe_busy",  64'(bus.busy), 64'd0);
    check("probe_stall", 64'(bus.dispatch_stall), 64'd0);
    check("probe_flush", 64'(bus.flush), 64'd0);
    quiet_inputs();
  endtask

  task automatic run_recovery(input bit br, input bit ld,
                              input logic [AW-1:0] pc,
                              input logic [AW-1:0] npc,
                              input logic [5:0] id,
                              input int d, input int r);
    int nd;
    int idle_k;
    int flushes;
    logic [AW-1:0] tgt;
    bit in_fl;
    bit in_rd;
    nd      = ((d > DT - 1) ? DT - 1 : d) + 1;
    idle_k  = nd + 2 + r + RES;
    flushes = 0;
    tgt     = ld ? pc : npc;
    @(negedge clk);
    check("pre_busy",  64'(bus.busy), 64'd0);
    check("pre_stall", 64'(bus.dispatch_stall), 64'd0);
    bus.head_valid      = 1'b1;
    bus.head_reg_ready  = 1'b1;
    bus.head_br_mispred = br;
    bus.head_ld_mispred = ld;
    bus.head_pc         = pc;
    bus.head_npc        = npc;
    bus.head_rob_id     = id;
    bus.fu_idle         = 1'($urandom);
    bus.redirect_ready  = 1'($urandom);
    if (exp_cnt != int'(CMAX)) exp_cnt++;
    for (int k = 0; k <= idle_k; k++) begin
      @(negedge clk);
      in_fl = (k == nd);
      in_rd = (k > nd) && (k <= nd + 1 + r);
      check("stall", 64'(bus.dispatch_stall), 64'(k < idle_k));
      check("busy",  64'(bus.busy), 64'(k < idle_k));
      check("flush", 64'(bus.flush), 64'(in_fl));
      check("brc",   64'(bus.br_commit), 64'(in_fl && !ld));
      check("rv",    64'(bus.redirect_valid), 64'(in_rd));
      if (in_rd) check("rpc", 64'(bus.redirect_pc), 64'(tgt));
      if (in_fl && !ld) check("cid", 64'(bus.commit_rob_id), 64'(id));
      if (bus.flush === 1'b1) flushes++;
      if (k == idle_k) begin
        quiet_inputs();
        bus.redirect_ready = 1'($urandom);
      end else begin
        garbage_head();
        if (k < nd) bus.fu_idle = (k >= d);
        else        bus.fu_idle = 1'($urandom);
        if (k > nd && k <= nd + 1 + r)
          bus.redirect_ready = ((k - (nd + 1)) >= r);
        else
          bus.redirect_ready = 1'($urandom);
      end
    end
    check("flush_once", 64'(flushes), 64'd1);
    check("cnt", 64'(bus.mispred_cnt), 64'(exp_cnt));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    rst_aL  = 1'b0;
    quiet_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_aL = 1'b1;

    idle_probe(1'b1, 1'b0, 1'b1, 1'b0);
    idle_probe(1'b1, 1'b1, 1'b0, 1'b0);
    idle_probe(1'b0, 1'b1, 1'b1, 1'b1);

    run_recovery(1'b1, 1'b0, 32'h100, 32'h200, 6'd5, 0, 0);
    run_recovery(1'b1, 1'b1, 32'h140, 32'h144, 6'd7, 0, 0);
    run_recovery(1'b0, 1'b1, 32'h300, 32'h304, 6'd9, 4, 0);
    run_recovery(1'b1, 1'b0, 32'h400, 32'h480, 6'd11, 40, 0);
    run_recovery(1'b1, 1'b0, 32'h500, 32'h5c0, 6'd13, 0, 3);

    @(negedge clk);
    bus.head_valid      = 1'b1;
    bus.head_reg_ready  = 1'b1;
    bus.head_br_mispred = 1'b1;
    bus.head_npc        = 32'hdead_beec;
    bus.head_rob_id     = 6'd21;
    bus.fu_idle         = 1'b0;
    @(negedge clk);
    quiet_inputs();
    bus.fu_idle = 1'b0;
    @(negedge clk);
    check("mid_busy", 64'(bus.busy), 64'd1);
    rst_aL = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst_aL = 1'b1;
    bus.fu_idle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_flush", 64'(bus.flush), 64'd0);
      check("post_busy",  64'(bus.busy), 64'd0);
    end

    for (int n = 0; n < 40; n++) begin
      int c;
      c = $urandom_range(1, 3);
      run_recovery(1'(c), 1'(c >> 1), $urandom, $urandom,
                   6'($urandom), $urandom_range(0, 17),
                   $urandom_range(0, 4));
    end
    check("sat", 64'(bus.mispred_cnt), 64'(CMAX));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
